// File: rtl/spi_pkg.sv
// Shared types for the SPI-attached byte RAM: command codes, per-port address FSM states
// and the received SPI word layout.
package spi_pkg;

  localparam int unsigned DEF_ADDR_SIZE = 8;
  localparam int unsigned DATA_W        = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic {
    NO_ADDR  = 1'b0,
    ADDR_SET = 1'b1
  } addr_state_e;

  typedef struct packed {
    cmd_e              cmd;
    logic [DATA_W-1:0] payload;
  } rx_word_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Byte storage for spi_ram: one write port and one registered read port.
// Array contents are never reset; only the read register is.
module spi_ram_mem
  import spi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register holds its value between reads.
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) begin
      rd_data_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/spi_ram.sv
// Command decoder and write/read address FSMs in front of spi_ram_mem.
// Optional feature: define SPI_RAM_AUTOINC_EN to post-increment addresses on executed data commands.
module spi_ram
  import spi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              seq_err
);

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  rx_word_t             rx_word;
  addr_state_e          wr_state_d, wr_state_q;
  addr_state_e          rd_state_d, rd_state_q;
  logic [ADDR_SIZE-1:0] wr_addr_d, wr_addr_q;
  logic [ADDR_SIZE-1:0] rd_addr_d, rd_addr_q;
  logic                 tx_valid_d, tx_valid_q;
  logic                 seq_err_d, seq_err_q;
  logic                 mem_we;
  logic                 mem_re;

  assign rx_word = rx_word_t'(rx_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_q <= NO_ADDR;
      rd_state_q <= NO_ADDR;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_valid_q <= tx_valid_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // One command per valid word; data commands without a prior address command are dropped.
  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    tx_valid_d = 1'b0;
    seq_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    if (rx_valid && rst_n) begin
      unique case (rx_word.cmd)
        CMD_WR_ADDR: begin
          wr_addr_d  = ADDR_SIZE'(rx_word.payload);
          wr_state_d = ADDR_SET;
        end
        CMD_WR_DATA: begin
          if (wr_state_q == ADDR_SET) begin
            mem_we = 1'b1;
            if (AUTOINC) wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
          end else begin
            seq_err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_d  = ADDR_SIZE'(rx_word.payload);
          rd_state_d = ADDR_SET;
        end
        CMD_RD_DATA: begin
          if (rd_state_q == ADDR_SET) begin
            mem_re     = 1'b1;
            tx_valid_d = 1'b1;
            if (AUTOINC) rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
          end else begin
            seq_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (wr_addr_q),
    .wdata (rx_word.payload),
    .re    (mem_re),
    .raddr (rd_addr_q),
    .rdata (tx_data)
  );

  assign tx_valid = tx_valid_q;
  assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// Scoreboard bench for spi_ram: the driver updates a behavioural model and queues expected
// pulses; an independent monitor checks every output cycle against that queue.
module tb_spi_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       seq_err;

  spi_ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .seq_err  (seq_err)
  );

  always #5 clk = ~clk;

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  // Behavioural model
  logic [7:0] ref_mem [256];
  bit         m_wr_set, m_rd_set;
  logic [7:0] m_wr_addr, m_rd_addr;

  function automatic void model_reset();
    m_wr_set  = 1'b0;
    m_rd_set  = 1'b0;
    m_wr_addr = 8'h00;
    m_rd_addr = 8'h00;
  endfunction

  task automatic send(input logic [1:0] cmd, input logic [7:0] pl);
    exp_t e;
    case (cmd)
      2'd0: begin m_wr_addr = pl; m_wr_set = 1'b1; end
      2'd1: begin
        if (m_wr_set) begin
          ref_mem[m_wr_addr] = pl;
          if (AUTOINC) m_wr_addr = m_wr_addr + 8'd1;
        end else begin
          e.is_err = 1'b1; e.data = 8'h00; exp_q.push_back(e);
        end
      end
      2'd2: begin m_rd_addr = pl; m_rd_set = 1'b1; end
      default: begin
        if (m_rd_set) begin
          e.is_err = 1'b0; e.data = ref_mem[m_rd_addr]; exp_q.push_back(e);
          if (AUTOINC) m_rd_addr = m_rd_addr + 8'd1;
        end else begin
          e.is_err = 1'b1; e.data = 8'h00; exp_q.push_back(e);
        end
      end
    endcase
    rx_data  = {cmd, pl};
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 10'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reset while presenting a would-be write, which must be ignored.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = {2'b01, 8'($urandom)};
    model_reset();
    repeat (2) begin @(posedge clk); #1; end
    rx_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  // Monitor: pops on every pulse, otherwise checks that tx_data holds.
  logic [7:0] held = 8'h00;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 8'h00;
      end else if (tx_valid || seq_err) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: tx_valid=%0b seq_err=%0b tx_data=%02h, required no pulse",
                   tx_valid, seq_err, tx_data);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err) begin
            if (!(seq_err && !tx_valid && tx_data == held)) begin
              n_err++;
              $display("FAIL seq_err_pulse: seq_err=%0b tx_valid=%0b tx_data=%02h, required 1/0/%02h",
                       seq_err, tx_valid, tx_data, held);
            end
          end else begin
            if (!(tx_valid && !seq_err && tx_data == e.data)) begin
              n_err++;
              $display("FAIL read_data: tx_valid=%0b seq_err=%0b tx_data=%02h, required 1/0/%02h",
                       tx_valid, seq_err, tx_data, e.data);
            end
            held = e.data;
          end
        end
      end else begin
        n_cmp++;
        if (tx_data !== held) begin
          n_err++;
          $display("FAIL tx_hold: tx_data=%02h, required %02h", tx_data, held);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] c;
    logic [7:0] p;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    model_reset();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;

    // Read before any read address: dropped with seq_err, tx_data stays 0.
    send(2'd3, 8'h00);
    idle(2);
    // Write before any write address: dropped with seq_err.
    send(2'd1, 8'h42);
    idle(1);

    // Fill the whole memory so every later read has a known value.
    for (int a = 0; a < 256; a++) begin
      send(2'd0, 8'(a));
      send(2'd1, 8'($urandom));
    end

    // Basic write then read.
    send(2'd0, 8'h10); send(2'd1, 8'hA5); send(2'd2, 8'h10); send(2'd3, 8'h00);
    idle(1);

    // Top address, back-to-back reads, wrap behaviour when auto-incrementing.
    send(2'd0, 8'hFF); send(2'd1, 8'h11); send(2'd2, 8'hFF); send(2'd3, 8'h00);
    send(2'd1, 8'h22); send(2'd3, 8'h00);
    idle(1);

    // Reset between address and data: write is dropped, old byte survives.
    send(2'd0, 8'h05);
    do_reset();
    send(2'd1, 8'h77);
    send(2'd2, 8'h05); send(2'd3, 8'h00);
    idle(1);

    // Read immediately after write, then long idle with tx_data holding.
    send(2'd0, 8'h20); send(2'd1, 8'h5A); send(2'd2, 8'h20); send(2'd3, 8'h00);
    idle(10);

    // Last address wins.
    send(2'd0, 8'h01); send(2'd0, 8'h02); send(2'd1, 8'hC3);
    send(2'd2, 8'h02); send(2'd3, 8'h00);
    send(2'd2, 8'h01); send(2'd3, 8'h00);
    idle(1);

    // Randomised traffic with idle gaps and occasional resets.
    for (int i = 0; i < 600; i++) begin
      c = 2'($urandom);
      p = 8'($urandom);
      if (p[7:5] == 3'd0 && $urandom_range(0, 1) == 0) p = 8'h10;
      send(c, p);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    idle(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_ram.md
SPI_RAM -- requirements
Module: spi_ram

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 8-bit words; fixed at 2**ADDR_SIZE.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, address width in bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port rx_data  input  10  SPI slave word; [9:8] command, [7:0] payload.
REQ-006 SHALL have port rx_valid  input  1  rx_data qualifier, one cycle per word.
REQ-007 SHALL have port tx_data  output  8  read data returned to the SPI slave.
REQ-008 SHALL have port tx_valid  output  1  tx_data qualifier, one-cycle pulse.
REQ-009 SHALL have port seq_err  output  1  one-cycle pulse on a command-sequence violation.

Function
REQ-010 SHALL act only on cycles with rx_valid=1; with rx_valid=0, all state and tx_data hold and tx_valid/seq_err are 0.
REQ-011 Command 00 (WR_ADDR) SHALL load wr_addr<=payload and set the write FSM to ADDR_SET.
REQ-012 Command 01 (WR_DATA) in write state ADDR_SET SHALL write mem[wr_addr]<=payload at that clock edge.
REQ-013 Command 10 (RD_ADDR) SHALL load rd_addr<=payload and set the read FSM to ADDR_SET.
REQ-014 Command 11 (RD_DATA) in read state ADDR_SET SHALL drive tx_data<=mem[rd_addr] with tx_valid=1 on the cycle after the command; latency is 1 clock.
REQ-015 The write and read FSMs SHALL each have two states: NO_ADDR (reset) -> ADDR_SET on the matching address command; ADDR_SET persists until reset.
REQ-016 WR_DATA in write state NO_ADDR SHALL be dropped (no memory write) and SHALL pulse seq_err on the next cycle.
REQ-017 RD_DATA in read state NO_ADDR SHALL be dropped (tx_valid stays 0, tx_data holds) and SHALL pulse seq_err on the next cycle.
REQ-018 RD_DATA issued on the cycle after a WR_DATA to the same address SHALL return the newly written byte.
REQ-019 A repeated address command SHALL overwrite the address register; the last value wins.
REQ-020 tx_data SHALL hold its last value after the tx_valid pulse ends.
REQ-021 Only one command SHALL be processed per cycle; the write and read address registers are independent.

Reset
REQ-022 With rst_n=0 at a clock edge: tx_data=0, tx_valid=0, seq_err=0, wr_addr=0, rd_addr=0, both FSMs=NO_ADDR.
REQ-023 Memory contents SHALL NOT be cleared by reset.
REQ-024 rx_valid SHALL be ignored on any cycle with rst_n=0; a reset mid-sequence SHALL return both FSMs to NO_ADDR.

Configuration
REQ-025 Macro SPI_RAM_AUTOINC_EN defined: each executed WR_DATA SHALL post-increment wr_addr and each executed RD_DATA SHALL post-increment rd_addr, modulo MEM_DEPTH (255->0).
REQ-026 Macro SPI_RAM_AUTOINC_EN undefined: address registers SHALL change only on address commands.
REQ-027 Dropped commands (REQ-016, REQ-017) SHALL never increment an address.

Structure
REQ-028 Shared package spi_pkg SHALL hold the command enum (CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11), the addr-FSM state enum (NO_ADDR, ADDR_SET), and the default ADDR_SIZE constant.
REQ-029 The storage array SHALL be a single sub-module spi_ram_mem (1 write port, 1 registered read port); the command decode and both FSMs live in spi_ram.

Verification
REQ-030 Reset, then RD_DATA 0x3_00 -> next cycle seq_err=1, tx_valid=0, tx_data=0x00.
REQ-031 0x0_10, 0x1_A5, 0x2_10, 0x3_00 -> tx_data=0xA5 with tx_valid=1 exactly one cycle after the 0x3_00 word.
REQ-032 0x0_FF, 0x1_11, 0x2_FF, back-to-back 0x3_00 -> tx_data=0x11; with SPI_RAM_AUTOINC_EN, write 0x1_22 lands at 0x00 (wrap) and a second 0x3_00 returns mem[0x00]=0x22.
REQ-033 0x0_05, rst_n=0 for 1 cycle, then 0x1_77 -> seq_err=1, and a later read of 0x05 does not return 0x77.
REQ-034 0x0_20, 0x1_5A, 0x2_20, immediately 0x3_00 -> 0x5A; rx_valid held low 10 cycles -> tx_data stays 0x5A, tx_valid=0.
REQ-035 0x0_01, 0x0_02, 0x1_C3, 0x2_02, 0x3_00 -> 0xC3 (last address wins); a read of address 0x01 does not return 0xC3.
